// File: rtl/btb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : btb_fetch_stage
//  Purpose  : Instruction-fetch stage of the pipelined MIPS core. Holds the
//             PC, performs a same-cycle direct-mapped BTB lookup to pick the
//             next PC, and registers the fetched instruction into IF/ID.
//             EX-stage resolution trains the BTB; an EX mispredict redirects
//             fetch and flushes IF/ID.
//  Ports    : Clk, Rst (async, active-low)
//             Stall            - hold PC and IF/ID
//             Instruction      - imem read data for PC (combinational memory)
//             PC               - current fetch address
//             IFID_*           - IF/ID latch: instruction, PC+4, prediction
//             ResValid/ResPC/ResTaken/ResTarget - BTB training from EX
//             Redirect/RedirectPC               - mispredict recovery
//  Revision : 1.0 - initial release
// ============================================================================
module btb_fetch_stage #(
    parameter int          ENTRIES  = 16,
    parameter int          IDX_BITS = 4,
    parameter logic [31:0] PC_RESET = 32'h00000000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic [31:0] Instruction,
    output logic [31:0] PC,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_PredTaken,
    output logic [31:0] IFID_PredTarget,
    input  logic        ResValid,
    input  logic [31:0] ResPC,
    input  logic        ResTaken,
    input  logic [31:0] ResTarget,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC
);

    localparam int         c_TAG_W    = 32 - IDX_BITS - 2;
    localparam logic [1:0] c_CTR_INIT = 2'b01;  // weakly not-taken
    localparam logic [1:0] c_CTR_ALOC = 2'b10;  // weakly taken on allocate
    localparam logic [1:0] c_CTR_MAX  = 2'b11;
    localparam logic [1:0] c_CTR_MIN  = 2'b00;

    // ------------------------------------------------------------------
    // BTB storage
    // ------------------------------------------------------------------
    logic [ENTRIES-1:0] r_valid;
    logic [1:0]         r_ctr    [ENTRIES];
    logic [c_TAG_W-1:0] r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic [31:0] r_pc;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc4;
    logic        r_ifid_pt;
    logic [31:0] r_ifid_ptgt;

    // ------------------------------------------------------------------
    // Fetch-side lookup (combinational, sees pre-update BTB contents)
    // ------------------------------------------------------------------
    logic [IDX_BITS-1:0] w_idx;
    logic [c_TAG_W-1:0]  w_tag;
    logic                w_hit;
    logic                w_pred_taken;
    logic [31:0]         w_pc_plus4;
    logic [31:0]         w_next_pc;

    assign w_idx        = r_pc[IDX_BITS+1:2];
    assign w_tag        = r_pc[31:IDX_BITS+2];
    assign w_hit        = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_pred_taken = w_hit && r_ctr[w_idx][1];
    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_next_pc    = w_pred_taken ? r_target[w_idx] : w_pc_plus4;

    // ------------------------------------------------------------------
    // Resolve-side lookup for training
    // ------------------------------------------------------------------
    logic [IDX_BITS-1:0] w_res_idx;
    logic [c_TAG_W-1:0]  w_res_tag;
    logic                w_res_hit;
    logic [1:0]          w_res_ctr;
    logic [1:0]          w_res_ctr_next;

    assign w_res_idx = ResPC[IDX_BITS+1:2];
    assign w_res_tag = ResPC[31:IDX_BITS+2];
    assign w_res_hit = r_valid[w_res_idx] && (r_tag[w_res_idx] == w_res_tag);
    assign w_res_ctr = r_ctr[w_res_idx];

    always_comb begin
        w_res_ctr_next = w_res_ctr;
        if (ResTaken) begin
            if (w_res_ctr != c_CTR_MAX) begin
                w_res_ctr_next = w_res_ctr + 2'b01;
            end
        end else begin
            if (w_res_ctr != c_CTR_MIN) begin
                w_res_ctr_next = w_res_ctr - 2'b01;
            end
        end
    end

    // Valid bits and counters carry reset state; a miss-and-not-taken
    // resolution leaves the entry untouched so aliases are not disturbed.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= c_CTR_INIT;
            end
        end else if (ResValid) begin
            if (w_res_hit) begin
                r_ctr[w_res_idx] <= w_res_ctr_next;
            end else if (ResTaken) begin
                r_valid[w_res_idx] <= 1'b1;
                r_ctr[w_res_idx]   <= c_CTR_ALOC;
            end
        end
    end

    // Tags and targets need no reset: they are qualified by the valid bit.
    // Any taken resolution either refreshes the target of a hitting entry
    // (tag unchanged) or allocates the entry with the new tag.
    always_ff @(posedge Clk) begin
        if (Rst && ResValid && ResTaken) begin
            r_tag[w_res_idx]    <= w_res_tag;
            r_target[w_res_idx] <= ResTarget;
        end
    end

    // ------------------------------------------------------------------
    // PC and IF/ID latch: Redirect > Stall > normal fetch
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_pc         <= PC_RESET;
            r_ifid_instr <= '0;
            r_ifid_pc4   <= '0;
            r_ifid_pt    <= 1'b0;
            r_ifid_ptgt  <= '0;
        end else if (Redirect) begin
            // Flush IF/ID to a NOP with no prediction attached.
            r_pc         <= RedirectPC;
            r_ifid_instr <= '0;
            r_ifid_pc4   <= '0;
            r_ifid_pt    <= 1'b0;
            r_ifid_ptgt  <= '0;
        end else if (!Stall) begin
            r_pc         <= w_next_pc;
            r_ifid_instr <= Instruction;
            r_ifid_pc4   <= w_pc_plus4;
            r_ifid_pt    <= w_pred_taken;
            r_ifid_ptgt  <= w_next_pc;
        end
    end

    assign PC               = r_pc;
    assign IFID_Instruction = r_ifid_instr;
    assign IFID_PCPlus4     = r_ifid_pc4;
    assign IFID_PredTaken   = r_ifid_pt;
    assign IFID_PredTarget  = r_ifid_ptgt;

endmodule
`default_nettype wire

// File: tb/tb_btb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_btb_fetch_stage
//  Purpose  : Self-checking bench for btb_fetch_stage. Directed scenarios
//             plus randomized traffic checked against a behavioural model of
//             the fetch stage and its BTB kept at the level of PC arithmetic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_btb_fetch_stage;

    localparam int c_ENTRIES = 16;

    logic        Clk;
    logic        Rst;
    logic        Stall;
    logic [31:0] Instruction;
    logic [31:0] PC;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_PredTaken;
    logic [31:0] IFID_PredTarget;
    logic        ResValid;
    logic [31:0] ResPC;
    logic        ResTaken;
    logic [31:0] ResTarget;
    logic        Redirect;
    logic [31:0] RedirectPC;

    int vectors = 0;
    int fails   = 0;

    btb_fetch_stage #(
        .ENTRIES  (16),
        .IDX_BITS (4),
        .PC_RESET (32'h00000000)
    ) dut (
        .Clk              (Clk),
        .Rst              (Rst),
        .Stall            (Stall),
        .Instruction      (Instruction),
        .PC               (PC),
        .IFID_Instruction (IFID_Instruction),
        .IFID_PCPlus4     (IFID_PCPlus4),
        .IFID_PredTaken   (IFID_PredTaken),
        .IFID_PredTarget  (IFID_PredTarget),
        .ResValid         (ResValid),
        .ResPC            (ResPC),
        .ResTaken         (ResTaken),
        .ResTarget        (ResTarget),
        .Redirect         (Redirect),
        .RedirectPC       (RedirectPC)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Instruction memory: a nonzero PC-dependent pattern.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    assign Instruction = imem(PC);

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [31:0] m_pc, m_ii, m_p4, m_ptg;
    logic        m_pt;
    bit          mv  [c_ENTRIES];
    logic [31:0] mpc [c_ENTRIES];   // full PC of the branch that owns the entry
    logic [31:0] mtg [c_ENTRIES];
    int          mct [c_ENTRIES];

    function automatic void m_reset();
        m_pc = 32'h0; m_ii = 32'h0; m_p4 = 32'h0; m_pt = 1'b0; m_ptg = 32'h0;
        for (int i = 0; i < c_ENTRIES; i++) begin
            mv[i] = 1'b0; mct[i] = 1; mpc[i] = 32'h0; mtg[i] = 32'h0;
        end
    endfunction

    function automatic int m_index(input logic [31:0] pc);
        return int'((pc / 32'd4) % c_ENTRIES);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        int idx = m_index(pc);
        return mv[idx] && ((mpc[idx] / 32'd64) == (pc / 32'd64));
    endfunction

    function automatic bit m_lookup(input logic [31:0] pc, output logic [31:0] tgt);
        int idx = m_index(pc);
        tgt = mtg[idx];
        return m_hit(pc) && (mct[idx] >= 2);
    endfunction

    function automatic void m_train(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
        int idx = m_index(pc);
        if (m_hit(pc)) begin
            if (tk) begin
                if (mct[idx] < 3) mct[idx] = mct[idx] + 1;
                mtg[idx] = tg;
            end else if (mct[idx] > 0) begin
                mct[idx] = mct[idx] - 1;
            end
        end else if (tk) begin
            mv[idx] = 1'b1; mpc[idx] = pc; mtg[idx] = tg; mct[idx] = 2;
        end
    endfunction

    // Advance one clock: model consumes the inputs as driven, DUT likewise.
    task automatic tick();
        logic [31:0] tgt, npc;
        logic        pt;
        pt  = m_lookup(m_pc, tgt);
        npc = pt ? tgt : m_pc + 32'd4;
        @(posedge Clk);
        if (Redirect) begin
            m_pc = RedirectPC; m_ii = 32'h0; m_p4 = 32'h0; m_pt = 1'b0; m_ptg = 32'h0;
        end else if (!Stall) begin
            m_ii = imem(m_pc); m_p4 = m_pc + 32'd4; m_pt = pt; m_ptg = npc; m_pc = npc;
        end
        if (ResValid) m_train(ResPC, ResTaken, ResTarget);
        #1;
    endtask

    task automatic idle();
        Stall = 1'b0; Redirect = 1'b0; ResValid = 1'b0; ResTaken = 1'b0;
    endtask

    task automatic go_to(input logic [31:0] a);
        Redirect = 1'b1; RedirectPC = a;
        tick();
        Redirect = 1'b0;
    endtask

    task automatic train(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
        ResValid = 1'b1; ResPC = pc; ResTaken = tk; ResTarget = tg;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        Rst = 1'b0; idle(); RedirectPC = 32'h0; ResPC = 32'h0; ResTarget = 32'h0;
        repeat (2) @(posedge Clk);
        #1;
        vectors++;
        if (PC !== 32'h0 || IFID_Instruction !== 32'h0 || IFID_PCPlus4 !== 32'h0 ||
            IFID_PredTaken !== 1'b0 || IFID_PredTarget !== 32'h0) begin
            fails++;
            $display("FAIL reset: PC=%h ii=%h p4=%h pt=%b ptg=%h, required all zero",
                     PC, IFID_Instruction, IFID_PCPlus4, IFID_PredTaken, IFID_PredTarget);
        end
        @(negedge Clk);
        Rst = 1'b1;
        m_reset();
    endtask

    task automatic test_sequential();
        for (int k = 1; k <= 4; k++) begin
            tick();
            vectors++;
            if (PC !== 32'(4 * k) || IFID_PCPlus4 !== 32'(4 * k) || IFID_PredTaken !== 1'b0 ||
                IFID_Instruction !== imem(32'(4 * (k - 1)))) begin
                fails++;
                $display("FAIL seq[%0d]: PC=%h p4=%h pt=%b ii=%h, required PC=%h p4=%h pt=0 ii=%h",
                         k, PC, IFID_PCPlus4, IFID_PredTaken, IFID_Instruction,
                         32'(4 * k), 32'(4 * k), imem(32'(4 * (k - 1))));
            end
        end
    endtask

    task automatic test_allocate();
        train(32'h10, 1'b1, 32'h40);
        go_to(32'h10);
        idle();
        tick();
        vectors++;
        if (PC !== 32'h40 || IFID_PredTaken !== 1'b1 || IFID_PredTarget !== 32'h40 ||
            IFID_PCPlus4 !== 32'h14) begin
            fails++;
            $display("FAIL allocate: PC=%h pt=%b ptg=%h p4=%h, required PC=40 pt=1 ptg=40 p4=14",
                     PC, IFID_PredTaken, IFID_PredTarget, IFID_PCPlus4);
        end
    endtask

    task automatic test_counter();
        // 10 -> 01: predicts not taken
        train(32'h10, 1'b0, 32'h0);
        go_to(32'h10);
        idle();
        tick();
        vectors++;
        if (PC !== 32'h14 || IFID_PredTaken !== 1'b0) begin
            fails++;
            $display("FAIL ctr_nt: PC=%h pt=%b, required PC=14 pt=0", PC, IFID_PredTaken);
        end
        // 01 -> 10 -> 11
        train(32'h10, 1'b1, 32'h40);
        tick(); tick();
        idle();
        go_to(32'h10);
        tick();
        vectors++;
        if (PC !== 32'h40 || IFID_PredTaken !== 1'b1) begin
            fails++;
            $display("FAIL ctr_t2: PC=%h pt=%b, required PC=40 pt=1", PC, IFID_PredTaken);
        end
        // 11 saturates, then one not-taken leaves it at 10: still taken
        train(32'h10, 1'b1, 32'h40);
        tick();
        train(32'h10, 1'b0, 32'h0);
        tick();
        idle();
        go_to(32'h10);
        tick();
        vectors++;
        if (PC !== 32'h40 || IFID_PredTaken !== 1'b1) begin
            fails++;
            $display("FAIL ctr_sat: PC=%h pt=%b, required PC=40 pt=1", PC, IFID_PredTaken);
        end
        // 10 -> 01, trained during the redirect cycle
        train(32'h10, 1'b0, 32'h0);
        go_to(32'h10);
        idle();
        tick();
        vectors++;
        if (PC !== 32'h14 || IFID_PredTaken !== 1'b0) begin
            fails++;
            $display("FAIL ctr_dec: PC=%h pt=%b, required PC=14 pt=0", PC, IFID_PredTaken);
        end
    endtask

    task automatic test_redirect_stall();
        logic [31:0] s_pc, s_ii, s_p4, s_ptg;
        logic        s_pt;
        Stall = 1'b1; Redirect = 1'b1; RedirectPC = 32'h100;
        tick();
        vectors++;
        if (PC !== 32'h100 || IFID_Instruction !== 32'h0 || IFID_PredTaken !== 1'b0 ||
            IFID_PCPlus4 !== 32'h0 || IFID_PredTarget !== 32'h0) begin
            fails++;
            $display("FAIL redirect: PC=%h ii=%h pt=%b p4=%h ptg=%h, required PC=100 rest zero",
                     PC, IFID_Instruction, IFID_PredTaken, IFID_PCPlus4, IFID_PredTarget);
        end
        idle();
        tick();
        s_pc = PC; s_ii = IFID_Instruction; s_p4 = IFID_PCPlus4; s_pt = IFID_PredTaken; s_ptg = IFID_PredTarget;
        Stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (PC !== 32'h104 || IFID_Instruction !== imem(32'h100) || PC !== s_pc ||
                IFID_Instruction !== s_ii || IFID_PCPlus4 !== s_p4 ||
                IFID_PredTaken !== s_pt || IFID_PredTarget !== s_ptg) begin
                fails++;
                $display("FAIL stall[%0d]: PC=%h ii=%h p4=%h, required PC=104 ii=%h p4=%h",
                         k, PC, IFID_Instruction, IFID_PCPlus4, imem(32'h100), 32'h104);
            end
        end
        idle();
    endtask

    task automatic test_alias();
        train(32'h10, 1'b1, 32'h40);
        tick();
        train(32'h50, 1'b1, 32'h80);
        tick();
        idle();
        go_to(32'h50);
        tick();
        vectors++;
        if (PC !== 32'h80 || IFID_PredTaken !== 1'b1 || IFID_PredTarget !== 32'h80) begin
            fails++;
            $display("FAIL alias_new: PC=%h pt=%b ptg=%h, required PC=80 pt=1 ptg=80",
                     PC, IFID_PredTaken, IFID_PredTarget);
        end
        go_to(32'h10);
        tick();
        vectors++;
        if (PC !== 32'h14 || IFID_PredTaken !== 1'b0) begin
            fails++;
            $display("FAIL alias_old: PC=%h pt=%b, required PC=14 pt=0", PC, IFID_PredTaken);
        end
        // Not-taken for an untrained PC sharing index 4 must change nothing.
        train(32'h90, 1'b0, 32'h0);
        tick();
        idle();
        go_to(32'h50);
        tick();
        vectors++;
        if (PC !== 32'h80 || IFID_PredTaken !== 1'b1) begin
            fails++;
            $display("FAIL alias_nt_keep: PC=%h pt=%b, required PC=80 pt=1", PC, IFID_PredTaken);
        end
        go_to(32'h90);
        tick();
        vectors++;
        if (PC !== 32'h94 || IFID_PredTaken !== 1'b0) begin
            fails++;
            $display("FAIL alias_nt_miss: PC=%h pt=%b, required PC=94 pt=0", PC, IFID_PredTaken);
        end
    endtask

    task automatic test_reset_midop();
        train(32'h10, 1'b1, 32'h40);
        go_to(32'h18);
        idle();
        tick(); tick();
        vectors++;
        if (PC !== 32'h20) begin
            fails++;
            $display("FAIL pre_reset_pc: PC=%h, required 20", PC);
        end
        #2 Rst = 1'b0;
        #1;
        vectors++;
        if (PC !== 32'h0 || IFID_Instruction !== 32'h0 || IFID_PredTaken !== 1'b0 ||
            IFID_PCPlus4 !== 32'h0 || IFID_PredTarget !== 32'h0) begin
            fails++;
            $display("FAIL async_reset: PC=%h ii=%h pt=%b p4=%h ptg=%h, required all zero",
                     PC, IFID_Instruction, IFID_PredTaken, IFID_PCPlus4, IFID_PredTarget);
        end
        @(posedge Clk);
        #1;
        vectors++;
        if (PC !== 32'h0 || IFID_Instruction !== 32'h0) begin
            fails++;
            $display("FAIL reset_hold: PC=%h ii=%h, required 0 0", PC, IFID_Instruction);
        end
        @(negedge Clk);
        Rst = 1'b1;
        m_reset();
        go_to(32'h10);
        tick();
        vectors++;
        if (PC !== 32'h14 || IFID_PredTaken !== 1'b0) begin
            fails++;
            $display("FAIL reset_clears_btb: PC=%h pt=%b, required PC=14 pt=0", PC, IFID_PredTaken);
        end
    endtask

    task automatic test_random();
        logic [31:0] pool [8];
        for (int i = 0; i < 8; i++) begin
            pool[i] = {($urandom_range(0, 3) == 0) ? 24'hFFFFFF : 24'h0, 8'h0} +
                      32'(4 * $urandom_range(0, 63));
        end
        for (int n = 0; n < 400; n++) begin
            Stall    = ($urandom_range(0, 3) == 0);
            Redirect = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0:       RedirectPC = 32'(4 * $urandom_range(0, 255));
                1:       RedirectPC = 32'hFFFFFFC0 + 32'(4 * $urandom_range(0, 15));
                2:       RedirectPC = pool[$urandom_range(0, 7)];
                default: RedirectPC = $urandom;
            endcase
            ResValid  = ($urandom_range(0, 1) == 1);
            ResPC     = ($urandom_range(0, 1) == 1) ? m_pc : pool[$urandom_range(0, 7)];
            ResTaken  = ($urandom_range(0, 2) != 0);
            ResTarget = ($urandom_range(0, 3) == 0) ? $urandom : pool[$urandom_range(0, 7)];
            tick();
            vectors++;
            if (PC !== m_pc || IFID_Instruction !== m_ii || IFID_PCPlus4 !== m_p4 ||
                IFID_PredTaken !== m_pt || IFID_PredTarget !== m_ptg) begin
                fails++;
                $display("FAIL random[%0d]: PC=%h ii=%h p4=%h pt=%b ptg=%h, required PC=%h ii=%h p4=%h pt=%b ptg=%h",
                         n, PC, IFID_Instruction, IFID_PCPlus4, IFID_PredTaken, IFID_PredTarget,
                         m_pc, m_ii, m_p4, m_pt, m_ptg);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_allocate();
        test_counter();
        test_redirect_stall();
        test_alias();
        test_reset_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
`default_nettype wire
